// File: rtl/pipeline_interlock_ctrl_pkg.sv
// Shared types and constants for the pipeline interlock controller.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [31:0] NOP_INST = 32'h6800_0000;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipeline_interlock_ctrl_if.sv
// Hazard inputs and stall/bubble/flush outputs between the pipeline and its interlock controller.
// Optional statistics counters appear when INTERLOCK_STATS_EN is defined.
import pipe_ctrl_pkg::*;

interface pipeline_interlock_ctrl_if;

  logic [REG_W-1:0] RP1_OF;
  logic [REG_W-1:0] RP2_OF;
  logic             use_RP1_OF;
  logic             use_RP2_OF;
  logic             is_Ld_ALU;
  logic             isWb_ALU;
  logic [REG_W-1:0] rd_ALU;
  logic             is_Mc_ALU;
  logic             isBranchTaken_ALU;

  logic             stall_PC;
  logic             stall_IFOF;
  logic             stall_OFALU;
  logic             bubble_OFALU;
  logic             flush_IFOF;
  logic             mc_done;
  logic             mc_busy;
  logic [31:0]      nop_inst;

`ifdef INTERLOCK_STATS_EN
  logic [31:0]      stat_ldstall;
  logic [31:0]      stat_mcstall;
  logic [31:0]      stat_flush;

  modport master (
    output RP1_OF, RP2_OF, use_RP1_OF, use_RP2_OF, is_Ld_ALU, isWb_ALU, rd_ALU,
           is_Mc_ALU, isBranchTaken_ALU,
    input  stall_PC, stall_IFOF, stall_OFALU, bubble_OFALU, flush_IFOF, mc_done, mc_busy,
           nop_inst, stat_ldstall, stat_mcstall, stat_flush
  );

  modport slave (
    input  RP1_OF, RP2_OF, use_RP1_OF, use_RP2_OF, is_Ld_ALU, isWb_ALU, rd_ALU,
           is_Mc_ALU, isBranchTaken_ALU,
    output stall_PC, stall_IFOF, stall_OFALU, bubble_OFALU, flush_IFOF, mc_done, mc_busy,
           nop_inst, stat_ldstall, stat_mcstall, stat_flush
  );
`else
  modport master (
    output RP1_OF, RP2_OF, use_RP1_OF, use_RP2_OF, is_Ld_ALU, isWb_ALU, rd_ALU,
           is_Mc_ALU, isBranchTaken_ALU,
    input  stall_PC, stall_IFOF, stall_OFALU, bubble_OFALU, flush_IFOF, mc_done, mc_busy,
           nop_inst
  );

  modport slave (
    input  RP1_OF, RP2_OF, use_RP1_OF, use_RP2_OF, is_Ld_ALU, isWb_ALU, rd_ALU,
           is_Mc_ALU, isBranchTaken_ALU,
    output stall_PC, stall_IFOF, stall_OFALU, bubble_OFALU, flush_IFOF, mc_done, mc_busy,
           nop_inst
  );
`endif

endinterface

// File: rtl/pipeline_interlock_ctrl_hazard_match.sv
// Load-use hazard detect: ALU-stage load whose destination is read by the OF-stage instruction.
import pipe_ctrl_pkg::*;

module hazard_match (
  input  logic [REG_W-1:0] rp1,
  input  logic [REG_W-1:0] rp2,
  input  logic             use_rp1,
  input  logic             use_rp2,
  input  logic             is_ld,
  input  logic             is_wb,
  input  logic [REG_W-1:0] rd,
  output logic             hit
);

  // r0 gets no special treatment; a load into r0 still interlocks.
  assign hit = is_ld & is_wb & ((use_rp1 & (rp1 == rd)) | (use_rp2 & (rp2 == rd)));

endmodule

// File: rtl/pipeline_interlock_ctrl.sv
// Pipeline interlock controller: load-use bubble, multi-cycle ALU hold, taken-branch flush.
// Define INTERLOCK_STATS_EN to add load-use / multi-cycle / flush event counters.
import pipe_ctrl_pkg::*;

module pipeline_interlock_ctrl #(
  parameter int          MC_LATENCY = 4,
  parameter logic [31:0] NOP_INST   = pipe_ctrl_pkg::NOP_INST
) (
  input logic                      clk,
  input logic                      rst,
  pipeline_interlock_ctrl_if.slave bus
);

  // state   | meaning
  // RUN     | normal flow; branch flush, multi-cycle entry or load-use bubble
  // MC_WAIT | multi-cycle ALU op in progress; mc_cnt counts down to the done cycle

  localparam int CNT_W = $clog2(MC_LATENCY);

  state_t           state;
  logic [CNT_W-1:0] mc_cnt;
  logic             ld_hit;
  logic             mc_last;

  logic             stall_pc_c;
  logic             stall_ifof_c;
  logic             stall_ofalu_c;
  logic             bubble_c;
  logic             flush_c;
  logic             done_c;
  logic             busy_c;

  hazard_match u_hazard_match (
    .rp1     (bus.RP1_OF),
    .rp2     (bus.RP2_OF),
    .use_rp1 (bus.use_RP1_OF),
    .use_rp2 (bus.use_RP2_OF),
    .is_ld   (bus.is_Ld_ALU),
    .is_wb   (bus.isWb_ALU),
    .rd      (bus.rd_ALU),
    .hit     (ld_hit)
  );

  assign mc_last = (state == MC_WAIT) && (mc_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      mc_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!bus.isBranchTaken_ALU && bus.is_Mc_ALU) begin
            state  <= MC_WAIT;
            mc_cnt <= CNT_W'(MC_LATENCY - 2);
          end
        end
        MC_WAIT: begin
          if (mc_cnt == '0) state <= RUN;
          else              mc_cnt <= mc_cnt - 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Outputs act on the pipe registers in the same cycle, so they are decoded, not registered.
  always_comb begin
    stall_pc_c    = 1'b0;
    stall_ifof_c  = 1'b0;
    stall_ofalu_c = 1'b0;
    bubble_c      = 1'b0;
    flush_c       = 1'b0;
    done_c        = 1'b0;
    busy_c        = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (bus.isBranchTaken_ALU) begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
          end else if (bus.is_Mc_ALU) begin
            stall_pc_c    = 1'b1;
            stall_ifof_c  = 1'b1;
            stall_ofalu_c = 1'b1;
          end else if (ld_hit) begin
            stall_pc_c   = 1'b1;
            stall_ifof_c = 1'b1;
            bubble_c     = 1'b1;
          end
        end
        MC_WAIT: begin
          busy_c = 1'b1;
          if (mc_last) begin
            done_c = 1'b1;
          end else begin
            stall_pc_c    = 1'b1;
            stall_ifof_c  = 1'b1;
            stall_ofalu_c = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall_PC     = stall_pc_c;
  assign bus.stall_IFOF   = stall_ifof_c;
  assign bus.stall_OFALU  = stall_ofalu_c;
  assign bus.bubble_OFALU = bubble_c;
  assign bus.flush_IFOF   = flush_c;
  assign bus.mc_done      = done_c;
  assign bus.mc_busy      = busy_c;
  assign bus.nop_inst     = NOP_INST;

`ifdef INTERLOCK_STATS_EN
  logic [31:0] stat_ld_q;
  logic [31:0] stat_mc_q;
  logic [31:0] stat_fl_q;

  // A bubble without a flush can only come from the load-use path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ld_q <= '0;
      stat_mc_q <= '0;
      stat_fl_q <= '0;
    end else begin
      if (bubble_c && !flush_c) stat_ld_q <= stat_ld_q + 32'd1;
      if (stall_ofalu_c)        stat_mc_q <= stat_mc_q + 32'd1;
      if (flush_c)              stat_fl_q <= stat_fl_q + 32'd1;
    end
  end

  assign bus.stat_ldstall = stat_ld_q;
  assign bus.stat_mcstall = stat_mc_q;
  assign bus.stat_flush   = stat_fl_q;
`endif

endmodule
